// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single to 32-bit two's-complement fixed-point converter, one shift per cycle.
// Define SATURATE_EN to clamp overflowed results to the signed extremes instead of zero.
module float_to_fixed (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [4:0]  fixpointpos,
    input  logic [31:0] floatnumber,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {IDLE, UNPACK, SHIFT, FINISH} state_t;

    state_t state, state_next;

    logic        sign_r;
    logic [7:0]  exp_r;
    logic [22:0] frac_r;
    logic [4:0]  fpp_r;
    logic [31:0] mag;
    logic [4:0]  cnt;
    logic        shift_left;
    logic        force_ovf;

    logic signed [9:0] k;
    logic [4:0]  unpack_n;
    logic        unpack_left;
    logic        unpack_zero;
    logic        unpack_ovf;
    logic        finish_ovf;
    logic [31:0] sat_value;
    logic [31:0] finish_value;

    // Net shift needed to place the hidden-one mantissa at the requested binary point
    always_comb begin
        k = $signed({2'b00, exp_r}) + $signed({5'b00000, fpp_r}) - 10'sd150;
    end

    always_comb begin
        unpack_n    = 5'd0;
        unpack_left = 1'b0;
        unpack_zero = 1'b0;
        unpack_ovf  = 1'b0;
        if (exp_r == 8'h00) begin
            unpack_zero = 1'b1;
        end else if (exp_r == 8'hFF) begin
            unpack_ovf = 1'b1;
        end else if (k > 10'sd8) begin
            unpack_ovf = 1'b1;
        end else if (k >= 10'sd0) begin
            unpack_left = 1'b1;
            unpack_n    = k[4:0];
        end else if (k >= -10'sd23) begin
            unpack_n    = 5'(-k);
        end else begin
            unpack_zero = 1'b1;
        end
    end

    // Only the most negative value may legitimately have bit 31 set
    always_comb begin
        finish_ovf = force_ovf | (mag[31] & ~(sign_r & (mag == 32'h80000000)));
`ifdef SATURATE_EN
        sat_value  = sign_r ? 32'h80000000 : 32'h7FFFFFFF;
`else
        sat_value  = 32'h00000000;
`endif
        finish_value = finish_ovf ? sat_value : (sign_r ? (~mag + 32'd1) : mag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (start) state_next = UNPACK;
            UNPACK:  state_next = (unpack_n == 5'd0) ? FINISH : SHIFT;
            SHIFT:   if (cnt <= 5'd1) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_r     <= 1'b0;
            exp_r      <= 8'd0;
            frac_r     <= 23'd0;
            fpp_r      <= 5'd0;
            mag        <= 32'd0;
            cnt        <= 5'd0;
            shift_left <= 1'b0;
            force_ovf  <= 1'b0;
            result     <= 32'd0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_r <= floatnumber[31];
                        exp_r  <= floatnumber[30:23];
                        frac_r <= floatnumber[22:0];
                        fpp_r  <= fixpointpos;
                    end
                end
                UNPACK: begin
                    mag        <= unpack_zero ? 32'd0 : {8'd0, 1'b1, frac_r};
                    cnt        <= unpack_n;
                    shift_left <= unpack_left;
                    force_ovf  <= unpack_ovf;
                end
                SHIFT: begin
                    mag <= shift_left ? (mag << 1) : (mag >> 1);
                    cnt <= cnt - 5'd1;
                end
                FINISH: begin
                    result   <= finish_value;
                    overflow <= finish_ovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/float_to_fixed.md
# float_to_fixed

Iterative converter from IEEE-754 single precision to 32-bit two's-complement fixed point with a runtime-selected binary point. It is the inverse of the lab's fixed-to-float path and sits beside it in the datapath, so values can round-trip. It uses a start/done handshake, and a one-bit-per-cycle barrel-free shifter keeps area small at the cost of variable latency.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while idle
- fixpointpos  in  5  number of fractional bits in result (0–31); captured with start
- floatnumber  in  32  IEEE-754 single input {s, e[7:0], f[22:0]}; captured with start
- result  out  32  fixed-point result; holds until next done
- done  out  1  one-cycle pulse: result/overflow valid
- busy  out  1  high from capture edge until done pulse cycle (inclusive of FINISH)
- overflow  out  1  magnitude not representable; valid with done, held with result

## Operation
- Value = (-1)^s · 1.f · 2^(e-127); result = trunc_toward_zero(value · 2^fixpointpos).
- FSM: IDLE → UNPACK → SHIFT (n cycles, n may be 0) → FINISH → IDLE.
- IDLE: on start=1 capture inputs, busy←1. Start while busy is ignored (not queued).
- UNPACK: mag ← {8'b0, 1, f}; k = e − 150 + fixpointpos (signed, ≥10 bits).
  - e==0 (zero/denormal): force zero, n=0.
  - e==255 (Inf/NaN): force overflow, n=0.
  - k>8: force overflow, n=0.
  - 0≤k≤8: left shift, n=k.
  - −23≤k<0: right shift, n=−k (bits shifted out discarded).
  - k≤−24: force zero, n=0.
- SHIFT: one bit per cycle in chosen direction; decrement counter; exit on zero.
- FINISH: if mag[31]==1 and not (s==1 and mag==32'h80000000), overflow. Otherwise result ← s ? −mag : mag. Register result/overflow, pulse done, busy←0.
- Overflow result per Configuration.

## Timing
- Start sampled at edge 0; UNPACK at edge 1; SHIFT occupies edges 2..n+1; FINISH at edge n+2; done high during cycle after edge n+2.
- Latency n+2 edges; min 2 (n=0), max 25 (n=23).
- Back-to-back: new start accepted at the first edge where done is high (state IDLE).
- Reset values: result=0, done=0, busy=0, overflow=0, state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately; no done pulse after release; result stays 0.
- fixpointpos/floatnumber changes after capture have no effect.

## Configuration
- SATURATE_EN defined: on overflow, result = 32'h7FFFFFFF (s=0) or 32'h80000000 (s=1); NaN saturates per its sign bit.
- SATURATE_EN undefined: on overflow, result = 32'h00000000.
- overflow flag behaves identically in both builds.

## Test plan
- fixpointpos=8, floatnumber=32'h40490000 (3.140625) → k=−14; done after edge 16; result=32'h00000324, overflow=0.
- fixpointpos=0, floatnumber=32'hC2F60000 (−123.0) → result=32'hFFFFFF85, overflow=0, latency 19 edges.
- fixpointpos=16: 32'h47000000 (32768.0) → overflow=1, result=32'h7FFFFFFF (SATURATE_EN) or 0. 32'hC7000000 → result=32'h80000000, overflow=0.
- 32'h00000000, 32'h80000000, 32'h00000001 (denormal), and 32'h3E800000 with fixpointpos=1 (0.25→trunc) → result=0, overflow=0, done after edge 2.
- 32'h7F800000 (+Inf) → overflow=1, done after edge 2. 32'h7FC00000 (NaN) → overflow=1.
- Start pulsed again while busy → ignored, single done. rst_n low mid-SHIFT → all outputs 0, no done. Next start after reset converts correctly.
